// File: rtl/ft245_async_rx_fifo.sv
// FT2232H asynchronous FT245 read front end: strobes usb_rdn, captures usb_d into a
// show-ahead FIFO and presents it as a valid/ready stream. Define FT245_RXF_SYNC_EN to synchronise usb_rxfn.
module ft245_async_rx_fifo #(
   parameter int RD_LOW_CYC  = 3,
   parameter int RD_HIGH_CYC = 2,
   parameter int FIFO_AW     = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [7:0]         usb_d,
   input  logic               usb_rxfn,
   output logic               usb_rdn,
   output logic [7:0]         m_data,
   output logic               m_valid,
   input  logic               m_ready,
   output logic [FIFO_AW:0]   fifo_level,
   output logic [15:0]        rx_count
);

   localparam int               DEPTH     = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] DEPTH_L   = (FIFO_AW+1)'(DEPTH);
   localparam logic [7:0]       LOW_LOAD  = 8'(RD_LOW_CYC - 1);
   localparam logic [7:0]       HIGH_LOAD = 8'(RD_HIGH_CYC - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_STROBE  = 2'd1,
      ST_RECOVER = 2'd2
   } state_t;

   state_t             state_r;
   logic [7:0]         cnt_r;
   logic               rdn_r;
   logic               rxf_q_s;
   logic [7:0]         mem_r [DEPTH];
   logic [FIFO_AW:0]   wr_ptr_r;
   logic [FIFO_AW:0]   rd_ptr_r;
   logic [FIFO_AW:0]   level_r;
   logic               valid_r;
   logic [7:0]         data_r;
   logic [15:0]        rx_count_r;

   logic               push_s;
   logic               pop_s;
   logic [FIFO_AW:0]   rd_next_s;
   logic [FIFO_AW:0]   level_next_s;
   logic [7:0]         head_next_s;

`ifdef FT245_RXF_SYNC_EN
   logic rxf_meta_r;
   logic rxf_sync_r;

   // Two-flop synchroniser for the asynchronous data-available pin.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rxf_meta_r <= 1'b1;
         rxf_sync_r <= 1'b1;
      end else begin
         rxf_meta_r <= usb_rxfn;
         rxf_sync_r <= rxf_meta_r;
      end
   end

   assign rxf_q_s = rxf_sync_r;
`else
   assign rxf_q_s = usb_rxfn;
`endif

   // Capture happens on the very edge that raises usb_rdn.
   assign push_s = (state_r == ST_STROBE) && (cnt_r == 8'd0);
   assign pop_s  = valid_r && m_ready;

   // Next read pointer, next occupancy and next head byte for the show-ahead register.
   always_comb begin
      rd_next_s    = rd_ptr_r;
      level_next_s = level_r;
      head_next_s  = data_r;
      if (pop_s) begin
         rd_next_s = rd_ptr_r + {{FIFO_AW{1'b0}}, 1'b1};
      end else begin
         rd_next_s = rd_ptr_r;
      end
      case ({push_s, pop_s})
         2'b10:   level_next_s = level_r + {{FIFO_AW{1'b0}}, 1'b1};
         2'b01:   level_next_s = level_r - {{FIFO_AW{1'b0}}, 1'b1};
         default: level_next_s = level_r;
      endcase
      // A byte written into the slot the head is about to point at bypasses the array.
      if (push_s && (wr_ptr_r[FIFO_AW-1:0] == rd_next_s[FIFO_AW-1:0])) begin
         head_next_s = usb_d;
      end else begin
         head_next_s = mem_r[rd_next_s[FIFO_AW-1:0]];
      end
   end

   // Strobe sequencer: IDLE -> STROBE (rdn low) -> RECOVER (rdn high) -> IDLE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
         cnt_r   <= 8'd0;
         rdn_r   <= 1'b1;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (!rxf_q_s && (level_r < DEPTH_L)) begin
                  state_r <= ST_STROBE;
                  rdn_r   <= 1'b0;
                  cnt_r   <= LOW_LOAD;
               end
            end
            ST_STROBE: begin
               if (cnt_r == 8'd0) begin
                  state_r <= ST_RECOVER;
                  rdn_r   <= 1'b1;
                  cnt_r   <= HIGH_LOAD;
               end else begin
                  cnt_r <= cnt_r - 8'd1;
               end
            end
            ST_RECOVER: begin
               if (cnt_r == 8'd0) begin
                  state_r <= ST_IDLE;
               end else begin
                  cnt_r <= cnt_r - 8'd1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               rdn_r   <= 1'b1;
               cnt_r   <= 8'd0;
            end
         endcase
      end
   end

   // FIFO storage; contents need no reset since pointers define validity.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r[FIFO_AW-1:0]] <= usb_d;
      end
   end

   // Pointers, occupancy, stream outputs and capture counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         level_r    <= '0;
         valid_r    <= 1'b0;
         data_r     <= 8'h00;
         rx_count_r <= 16'h0000;
      end else begin
         if (push_s) begin
            wr_ptr_r   <= wr_ptr_r + {{FIFO_AW{1'b0}}, 1'b1};
            rx_count_r <= rx_count_r + 16'd1;
         end
         rd_ptr_r <= rd_next_s;
         level_r  <= level_next_s;
         valid_r  <= (level_next_s != '0);
         data_r   <= head_next_s;
      end
   end

   assign usb_rdn    = rdn_r;
   assign m_data     = data_r;
   assign m_valid    = valid_r;
   assign fifo_level = level_r;
   assign rx_count   = rx_count_r;

endmodule

// File: tb/tb_ft245_async_rx_fifo.sv
// Randomised bench for ft245_async_rx_fifo against a queue-based model of the
// strobe timing rules, the FIFO contents and the capture counter.
module tb_ft245_async_rx_fifo;

   localparam int RD_LOW  = 3;
   localparam int RD_HIGH = 2;
   localparam int AW      = 4;
   localparam int DEPTH   = 1 << AW;

   logic          clk = 1'b0;
   logic          reset;
   logic [7:0]    usb_d;
   logic          usb_rxfn;
   logic          usb_rdn;
   logic [7:0]    m_data;
   logic          m_valid;
   logic          m_ready;
   logic [AW:0]   fifo_level;
   logic [15:0]   rx_count;

   ft245_async_rx_fifo #(.RD_LOW_CYC(RD_LOW), .RD_HIGH_CYC(RD_HIGH), .FIFO_AW(AW)) dut (
      .clk(clk), .reset(reset), .usb_d(usb_d), .usb_rxfn(usb_rxfn), .usb_rdn(usb_rdn),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .fifo_level(fifo_level), .rx_count(rx_count)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [7:0]  mq[$];
   logic [15:0] rx_exp;
   logic        rdn_exp;
   int          low_len;
   int          high_len;
   int          strobes;
   logic        last_push;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void model_reset();
      mq.delete();
      rx_exp   = 16'h0000;
      rdn_exp  = 1'b1;
      low_len  = 0;
      high_len = RD_HIGH + 1;
   endfunction

   // Strobe rule: rdn low exactly RD_LOW cycles, then high RD_HIGH+1 cycles before the next
   // strobe may start; a strobe starts only with room in the FIFO and usb_rxfn low.
   function automatic logic push_due();
      return !rdn_exp && (low_len == RD_LOW);
   endfunction

   task automatic step();
      logic       push_e, pop_e, start_e;
      logic [7:0] d_b;
      int         lvl_b;
      lvl_b   = mq.size();
      d_b     = usb_d;
      pop_e   = (lvl_b != 0) && m_ready;
      push_e  = push_due();
      start_e = rdn_exp && (high_len >= RD_HIGH + 1) && !usb_rxfn && (lvl_b < DEPTH);
      @(posedge clk);
      #1;
      if (pop_e) void'(mq.pop_front());
      if (push_e) begin
         mq.push_back(d_b);
         rx_exp   = rx_exp + 16'd1;
         rdn_exp  = 1'b1;
         high_len = 1;
      end else if (start_e) begin
         rdn_exp = 1'b0;
         low_len = 1;
         strobes++;
      end else if (!rdn_exp) begin
         low_len++;
      end else begin
         high_len++;
      end
      last_push = push_e;
      check_eq("usb_rdn", {31'd0, usb_rdn}, {31'd0, rdn_exp});
      check_eq("fifo_level", {27'd0, fifo_level}, mq.size());
      check_eq("m_valid", {31'd0, m_valid}, {31'd0, (mq.size() != 0)});
      check_eq("rx_count", {16'd0, rx_count}, {16'd0, rx_exp});
      if (mq.size() != 0) check_eq("m_data", {24'd0, m_data}, {24'd0, mq[0]});
   endtask

   initial begin
      int lowcnt, maxlvl, sv_strobes, i;
      reset    = 1'b0;
      usb_d    = 8'h00;
      usb_rxfn = 1'b1;
      m_ready  = 1'b0;
      strobes  = 0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_rdn", {31'd0, usb_rdn}, 32'd1);
      check_eq("rst_valid", {31'd0, m_valid}, 32'd0);
      check_eq("rst_level", {27'd0, fifo_level}, 32'd0);
      check_eq("rst_rxcnt", {16'd0, rx_count}, 32'd0);
      reset = 1'b1;
      step();

      // Single byte
      usb_d    = 8'h31;
      usb_rxfn = 1'b0;
      lowcnt   = 0;
      step();
      usb_rxfn = 1'b1;
      if (!usb_rdn) lowcnt++;
      for (i = 0; i < 8; i++) begin
         step();
         if (!usb_rdn) lowcnt++;
      end
      check_eq("single_lowcyc", lowcnt, RD_LOW);
      check_eq("single_data", {24'd0, m_data}, 32'h31);
      check_eq("single_level", {27'd0, fifo_level}, 32'd1);
      check_eq("single_rxcnt", {16'd0, rx_count}, 32'd1);
      m_ready = 1'b1;
      step();
      check_eq("single_popped", {31'd0, m_valid}, 32'd0);

      // Burst 0x00..0x3F with consumer always ready
      usb_d      = 8'h00;
      usb_rxfn   = 1'b0;
      maxlvl     = 0;
      sv_strobes = strobes;
      for (i = 0; i < 64 * 6 + 20 && usb_d != 8'h40; i++) begin
         step();
         if (fifo_level > maxlvl) maxlvl = fifo_level;
         if (last_push) usb_d = usb_d + 8'd1;
      end
      check_eq("burst_count", {24'd0, usb_d}, 32'h40);
      check_eq("burst_strobes", strobes - sv_strobes, 64);
      check_eq("burst_maxlvl", maxlvl, 1);
      usb_rxfn = 1'b1;
      repeat (8) step();

      // Full: consumer stalled
      m_ready    = 1'b0;
      usb_rxfn   = 1'b0;
      sv_strobes = strobes;
      for (i = 0; i < DEPTH * 6 + 30; i++) begin
         usb_d = 8'($urandom);
         step();
      end
      check_eq("full_level", {27'd0, fifo_level}, DEPTH);
      check_eq("full_strobes", strobes - sv_strobes, DEPTH);
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      for (i = 0; i < 30; i++) begin
         usb_d = 8'($urandom);
         step();
      end
      check_eq("full_one_more", strobes - sv_strobes, DEPTH + 1);
      check_eq("full_level2", {27'd0, fifo_level}, DEPTH);

      // Drain to 5, then pop on the capture edge
      usb_rxfn = 1'b1;
      for (i = 0; i < 40 && mq.size() > 5; i++) begin
         m_ready = 1'b1;
         step();
      end
      m_ready  = 1'b0;
      step();
      usb_rxfn = 1'b0;
      last_push = 1'b0;
      for (i = 0; i < 40 && !last_push; i++) begin
         m_ready = push_due();
         usb_d   = 8'($urandom);
         step();
      end
      m_ready  = 1'b0;
      usb_rxfn = 1'b1;
      check_eq("simul_push", {31'd0, last_push}, 32'd1);
      check_eq("simul_level", {27'd0, fifo_level}, 32'd5);
      for (i = 0; i < 60 && mq.size() != 0; i++) begin
         m_ready = 1'b1;
         step();
      end

      // Reset during the second low cycle
      m_ready  = 1'b0;
      usb_rxfn = 1'b0;
      for (i = 0; i < 20 && !(!rdn_exp && low_len == 2); i++) step();
      check_eq("mid_reached", {31'd0, (!rdn_exp && low_len == 2)}, 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check_eq("mid_rdn_high", {31'd0, usb_rdn}, 32'd1);
      model_reset();
      usb_rxfn = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      check_eq("mid_level", {27'd0, fifo_level}, 32'd0);
      check_eq("mid_rxcnt", {16'd0, rx_count}, 32'd0);
      check_eq("mid_valid", {31'd0, m_valid}, 32'd0);
      step();

      // Random traffic
      for (i = 0; i < 2000; i++) begin
         usb_rxfn = ($urandom_range(0, 3) == 0);
         m_ready  = ($urandom_range(0, 2) != 0);
         usb_d    = 8'($urandom);
         step();
      end

      // rx_count wrap
      usb_rxfn = 1'b1;
      m_ready  = 1'b1;
      repeat (10) step();
      force dut.rx_count_r = 16'hFFFD;
      @(negedge clk);
      release dut.rx_count_r;
      rx_exp   = 16'hFFFD;
      usb_rxfn = 1'b0;
      for (i = 0; i < 60 && rx_exp != 16'h0000; i++) begin
         usb_d = 8'($urandom);
         step();
      end
      check_eq("rx_wrap", {16'd0, rx_count}, 32'd0);
      usb_rxfn = 1'b1;
      repeat (5) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
